// File: rtl/ecc_sched_pkg.sv
// Shared types and defaults for the GF(2^163) point-multiplication job scheduler.
package ecc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        RESP
    } sched_state_e;

    localparam int unsigned ECC_W            = 163;
    localparam int unsigned ECC_CORE_LATENCY = 800;
    // Widest NIST binary field; is_zero() accepts any operand up to this width.
    localparam int unsigned ECC_MAX_W        = 571;

    function automatic logic is_zero(input logic [ECC_MAX_W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/ecc_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above rr_ptr_i, wrapping.
module ecc_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [PW-1:0]   rr_ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o,
    output logic            gnt_any_o
);

    int unsigned cand;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        cand      = 0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        if (en_i) begin
            for (int o = NREQ - 1; o >= 0; o--) begin
                cand = (int'(rr_ptr_i) + o) % NREQ;
                if (req_valid_i[cand]) begin
                    gnt_idx_o = PW'(cand);
                    gnt_any_o = 1'b1;
                end
            end
        end
        gnt_o = gnt_any_o ? (NREQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/ecc_job_scheduler.sv
// Front-end for the point-multiplication core: arbitrates jobs, sequences the
// core reset/run window, captures results and returns them on a tagged response port.
//
// state | meaning
// IDLE  | waiting for a request; req_ready driven by the arbiter
// LOAD  | operands registered, core still held in reset
// RUN   | core released, latency counter running
// CAPT  | core results sampled into rsp_xq/rsp_yq, core back in reset
// RESP  | response presented until rsp_ready
module ecc_job_scheduler
    import ecc_sched_pkg::*;
#(
    parameter int unsigned W            = ECC_W,
    parameter int unsigned NREQ         = 2,
    parameter int unsigned IDW          = 1,
    parameter int unsigned CORE_LATENCY = ECC_CORE_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_k,
    input  logic [NREQ*W-1:0] req_xp,
    input  logic [NREQ*W-1:0] req_yp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_xq,
    output logic [W-1:0]      rsp_yq,
    output logic              rsp_inf,
    output logic              core_rst,
    output logic [W-1:0]      core_a,
    output logic [W-1:0]      core_b,
    output logic [W-1:0]      core_k,
    output logic [W-1:0]      core_xp,
    output logic [W-1:0]      core_yp,
    input  logic [W-1:0]      core_xq,
    input  logic [W-1:0]      core_yq,
    output logic              busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(CORE_LATENCY + 1);

    sched_state_e    state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            core_rst_q, core_rst_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, k_q, k_d, xp_q, xp_d, yp_q, yp_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_xq_q, rsp_xq_d, rsp_yq_q, rsp_yq_d;
    logic            rsp_inf_q, rsp_inf_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [W-1:0]    a_sel, b_sel, k_sel, xp_sel, yp_sel;

    ecc_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .en_i        (state_q == IDLE),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_any_o   (gnt_any)
    );

    assign a_sel  = req_a [int'(gnt_idx)*W +: W];
    assign b_sel  = req_b [int'(gnt_idx)*W +: W];
    assign k_sel  = req_k [int'(gnt_idx)*W +: W];
    assign xp_sel = req_xp[int'(gnt_idx)*W +: W];
    assign yp_sel = req_yp[int'(gnt_idx)*W +: W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            core_rst_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            xp_q        <= '0;
            yp_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_xq_q    <= '0;
            rsp_yq_q    <= '0;
            rsp_inf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            core_rst_q  <= core_rst_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            xp_q        <= xp_d;
            yp_q        <= yp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_xq_q    <= rsp_xq_d;
            rsp_yq_q    <= rsp_yq_d;
            rsp_inf_q   <= rsp_inf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        xp_d      = xp_q;
        yp_d      = yp_q;
        rsp_id_d  = rsp_id_q;
        rsp_xq_d  = rsp_xq_q;
        rsp_yq_d  = rsp_yq_q;
        rsp_inf_d = rsp_inf_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    k_d      = k_sel;
                    xp_d     = xp_sel;
                    yp_d     = yp_sel;
                    rsp_id_d = IDW'(gnt_idx);
                    rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    // k == 0 yields the point at infinity without touching the core.
                    if (is_zero(ECC_MAX_W'(k_sel))) begin
                        rsp_xq_d  = '0;
                        rsp_yq_d  = '0;
                        rsp_inf_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        rsp_inf_d = 1'b0;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_d   = CW'(CORE_LATENCY - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) state_d = CAPT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            CAPT: begin
                rsp_xq_d = core_xq;
                rsp_yq_d = core_yq;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        core_rst_d  = (state_d != RUN);
        rsp_valid_d = (state_d == RESP);
    end

    assign req_ready = gnt;
    assign busy      = (state_q != IDLE);
    assign core_rst  = core_rst_q;
    assign core_a    = a_q;
    assign core_b    = b_q;
    assign core_k    = k_q;
    assign core_xp   = xp_q;
    assign core_yp   = yp_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_xq    = rsp_xq_q;
    assign rsp_yq    = rsp_yq_q;
    assign rsp_inf   = rsp_inf_q;

endmodule
